if_id_buffer: RTL
=================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: fetch stage presents an entry.
REQ-004 SHALL have port in_ready, output, 1: buffer accepts an entry this cycle.
REQ-005 SHALL have port in_PC, input, 32: fetched PC.
REQ-006 SHALL have port in_Instr, input, 32: fetched instruction word.
REQ-007 SHALL have port in_ExcCode, input, 5: fetch exception code; 0 means none, 4 means fetch address error.
REQ-008 SHALL have port in_BD, input, 1: entry is in a branch delay slot.
REQ-009 SHALL have port flush, input, 1: discard all buffered entries.
REQ-010 SHALL have port out_valid, output, 1: head entry is available to decode.
REQ-011 SHALL have port out_ready, input, 1: decode consumes the head entry this cycle.
REQ-012 SHALL have ports out_PC (32), out_Instr (32), out_ExcCode (5) and out_BD (1), all outputs: head entry fields.
REQ-013 SHALL have port count, output, 2: number of occupied entries, 0 to 2.

Function
REQ-014 SHALL implement a 2-entry in-order FIFO of {PC, Instr, ExcCode, BD}, 70 bits per entry.
REQ-015 SHALL drive in_ready = (count != 2) combinationally from state only, never from in_valid or out_ready.
REQ-016 SHALL push the in_* fields when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-017 SHALL drive out_valid = (count != 0); head fields appear on out_* combinationally from storage.
REQ-018 SHALL drive out_PC, out_Instr, out_ExcCode and out_BD to 0 when count == 0.
REQ-019 SHALL have 1-cycle latency: an entry pushed at edge N is visible on out_* after edge N when the buffer was empty.
REQ-020 SHALL handle push and pop in the same cycle as follows: count unchanged; at count 1 the pushed entry becomes head after the edge.
REQ-021 SHALL not push at count 2, since in_ready is 0; a pop at count 2 gives count 1, and in_ready rises the next cycle.
REQ-022 SHALL ignore out_ready while empty; count does not underflow.
REQ-023 SHALL apply flush synchronously at the next edge, giving count 0; it overrides a same-cycle push and pop, and the push is dropped.
REQ-024 SHALL implement read and write pointers as 1-bit, wrapping 1 to 0; count tracks occupancy independently of pointer equality.
REQ-025 SHALL keep storage registers unchanged unless written; no other side effects.

Reset
REQ-026 SHALL, on reset assertion and independent of clk, force count to 0, both pointers to 0, out_valid to 0, in_ready to 1, and all out_* data fields to 0.
REQ-027 SHALL discard all contents on reset asserted mid-operation; the first push after reset deassertion lands in entry 0.
REQ-028 SHALL not require storage payload registers to be reset, since they are masked by REQ-018.

Configuration
REQ-029 SHALL support macro IF_ID_EXC_NOP_EN: when defined, an entry pushed with in_ExcCode != 0 stores Instr = 32'h00000000 (nop); PC, ExcCode and BD are stored verbatim.
REQ-030 SHALL, when IF_ID_EXC_NOP_EN is undefined, store in_Instr verbatim for every entry regardless of ExcCode.

Verification
REQ-031 SHALL cover single pass: push PC=0x3000, Instr=0x24010001, ExcCode=0 into empty buffer with out_ready=1 -> next cycle out_valid=1, out_PC=0x3000, out_Instr=0x24010001, count=1; after the following edge, count=0.
REQ-032 SHALL cover fill: out_ready=0, push 0x3000 then 0x3004 -> count=2, in_ready=0, out_PC=0x3000; a third push of 0x3008 is not accepted; set out_ready=1 -> heads 0x3000 then 0x3004 in order.
REQ-033 SHALL cover simultaneous push and pop at count 1: head 0x3000, push 0x3004 with out_ready=1 -> count stays 1, out_PC=0x3004.
REQ-034 SHALL cover flush: count=2 plus flush=1 with in_valid=1 (PC=0x3008) -> next cycle count=0, out_valid=0, out_PC=0; 0x3008 never appears.
REQ-035 SHALL cover exception entry: push PC=0x3002, Instr=0x12345678, ExcCode=4 -> out_ExcCode=4, out_PC=0x3002; out_Instr=0 with IF_ID_EXC_NOP_EN defined, 0x12345678 without.
REQ-036 SHALL cover async reset: assert reset mid-cycle at count=2 -> count=0, out_valid=0, in_ready=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/if_id_buffer.sv
// Two-entry in-order skid FIFO between fetch and decode, carrying {PC, Instr, ExcCode, BD}.
// Optional build macro IF_ID_EXC_NOP_EN: entries with a nonzero ExcCode store a nop as Instr.
module if_id_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_PC,
    input  logic [31:0] in_Instr,
    input  logic [4:0]  in_ExcCode,
    input  logic        in_BD,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_PC,
    output logic [31:0] out_Instr,
    output logic [4:0]  out_ExcCode,
    output logic        out_BD,
    output logic [1:0]  count
);

    logic [31:0] mem_pc    [2];
    logic [31:0] mem_instr [2];
    logic [4:0]  mem_exc   [2];
    logic        mem_bd    [2];

    logic        rd_ptr;
    logic        wr_ptr;
    logic        push;
    logic        pop;
    logic [31:0] wr_instr;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef IF_ID_EXC_NOP_EN
    assign wr_instr = (in_ExcCode != 5'd0) ? 32'h0000_0000 : in_Instr;
`else
    assign wr_instr = in_Instr;
`endif

    // Occupancy is tracked by count, so equal pointers never need disambiguating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_pc[wr_ptr]    <= in_PC;
            mem_instr[wr_ptr] <= wr_instr;
            mem_exc[wr_ptr]   <= in_ExcCode;
            mem_bd[wr_ptr]    <= in_BD;
        end
    end

    always_comb begin
        out_PC      = 32'd0;
        out_Instr   = 32'd0;
        out_ExcCode = 5'd0;
        out_BD      = 1'b0;
        if (out_valid) begin
            out_PC      = mem_pc[rd_ptr];
            out_Instr   = mem_instr[rd_ptr];
            out_ExcCode = mem_exc[rd_ptr];
            out_BD      = mem_bd[rd_ptr];
        end
    end

endmodule
